// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle for the multicycle control unit: opcode and
// memory handshake into the controller, datapath selects and status out.
interface multicycle_control_if #(
  parameter int OP_WIDTH  = 6,
  parameter int CNT_WIDTH = 16
);
  logic [OP_WIDTH-1:0]  opcode;
  logic                 mem_ready;
  logic                 mem_read;
  logic                 mem_write;
  logic                 iord;
  logic                 ir_write;
  logic                 pc_write;
  logic                 pc_write_cond;
  logic                 branch_ne;
  logic [1:0]           pc_source;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic                 alu_src_a;
  logic                 reg_dst;
  logic                 mem_to_reg;
  logic                 reg_write;
  logic [3:0]           state;
  logic                 illegal_op;
  logic [CNT_WIDTH-1:0] instr_cnt;

  modport master (
    input  opcode, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
           branch_ne, pc_source, alu_src_b, alu_op, alu_src_a, reg_dst,
           mem_to_reg, reg_write, state, illegal_op, instr_cnt
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
           branch_ne, pc_source, alu_src_b, alu_op, alu_src_a, reg_dst,
           mem_to_reg, reg_write, state, illegal_op, instr_cnt
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM (S0..S11) with retired-instruction counter.
// Define MCTRL_BNE_EN to decode opcode 000101 (bne) through the branch state.
module multicycle_control #(
  parameter int OP_WIDTH  = 6,
  parameter int CNT_WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_if.master bus
);

`ifdef MCTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  localparam logic [OP_WIDTH-1:0] OP_R    = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OP_BNE  = OP_WIDTH'(6'b000101);
  localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(6'b000010);
  localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(6'b001000);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11
  } state_t;

  state_t               state_q;
  logic [OP_WIDTH-1:0]  opcode_q;
  logic                 illegal_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  // NOTE: every register here is updated with <= so all next-state terms see
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        S_FETCH:  if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          opcode_q <= bus.opcode;
          case (bus.opcode)
            OP_R:         state_q <= S_EXEC;
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
            OP_ADDI:      state_q <= S_ADDIEX;
            default: begin
              if (BNE_EN && bus.opcode == OP_BNE) begin
                state_q <= S_BRANCH;
              end else begin
                state_q   <= S_FETCH;
                illegal_q <= 1'b1;
              end
            end
          endcase
        end
        // Only the decode-time copy steers lw/sw; the live opcode may have moved on.
        S_MEMADR: state_q <= (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (bus.mem_ready) state_q <= S_MEMWB;
        S_MEMWR: begin
          if (bus.mem_ready) begin
            state_q <= S_FETCH;
            cnt_q   <= cnt_q + CNT_WIDTH'(1);
          end
        end
        S_EXEC:   state_q <= S_ALUWB;
        S_ADDIEX: state_q <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
          state_q <= S_FETCH;
          cnt_q   <= cnt_q + CNT_WIDTH'(1);
        end
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Outputs decode the registered state; only fetch also looks at mem_ready,
  // so the IR/PC load lands on the cycle the read actually completes.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.iord          = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne     = 1'b0;
    bus.pc_source     = 2'b00;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.alu_src_a     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: bus.alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      S_MEMWB: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        bus.branch_ne     = BNE_EN && (opcode_q == OP_BNE);
      end
      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
      end
      S_ADDIWB: bus.reg_write = 1'b1;
      default: ;
    endcase
  end

  assign bus.state      = state_q;
  assign bus.illegal_op = illegal_q;
  assign bus.instr_cnt  = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: cycle table with scoreboard,
// plus reset-in-S3 and 16-jump counter-wrap sequences (CNT_WIDTH = 4).
module tb_multicycle_control;

`ifdef MCTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BAD  = 6'b111111;

  typedef struct packed {
    logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic       alu_src_a, reg_dst, mem_to_reg, reg_write;
  } ctrl_t;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    int         st;
  } vec_t;

  typedef struct {
    int         idx;
    int         st;
    ctrl_t      ctrl;
    logic       ill;
    logic [3:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  vec_t vecs[$];
  exp_t sb[$];

  multicycle_control_if #(.OP_WIDTH(6), .CNT_WIDTH(4)) bus ();

  multicycle_control #(.OP_WIDTH(6), .CNT_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ctrl_t act_ctrl;
  assign act_ctrl = {bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write,
                     bus.pc_write_cond, bus.branch_ne, bus.pc_source, bus.alu_src_b,
                     bus.alu_op, bus.alu_src_a, bus.reg_dst, bus.mem_to_reg, bus.reg_write};

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic ctrl_t exp_ctrl(int st, logic rdy, logic bne);
    ctrl_t c = '0;
    case (st)
      0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.iord = 1; end
      4:  begin c.mem_to_reg = 1; c.reg_write = 1; end
      5:  begin c.mem_write = 1; c.iord = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_dst = 1; c.reg_write = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                c.pc_source = 2'b01; c.branch_ne = bne; end
      9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
      10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      11: c.reg_write = 1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic add(logic [5:0] op, logic rdy, int st);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st;
    vecs.push_back(v);
  endtask

  // Scoreboard consumer: compares each pushed expectation mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("state", e.idx, 32'(bus.state), 32'(e.st));
      check("ctrl", e.idx, 32'(act_ctrl), 32'(e.ctrl));
      check("illegal_op", e.idx, 32'(bus.illegal_op), 32'(e.ill));
      check("instr_cnt", e.idx, 32'(bus.instr_cnt), 32'(e.cnt));
    end
  end

  initial begin
    logic [3:0] exp_cnt;
    logic [5:0] lat_op;
    int         prev_st;
    logic [3:0] want;

    // lw, no waits: latency 5
    add(LW,1,0); add(LW,1,1); add(LW,1,2); add(LW,1,3); add(LW,1,4);
    // lw at decode, opcode switched to sw during MEMADR: must still load
    add(LW,1,0); add(LW,1,1); add(SW,1,2); add(SW,1,3); add(SW,1,4);
    // lw with fetch and read waits
    add(LW,0,0); add(LW,0,0); add(LW,1,0); add(LW,1,1); add(LW,1,2);
    add(LW,0,3); add(LW,1,3); add(LW,1,4);
    // sw with 3 wait cycles in S5
    add(SW,1,0); add(SW,1,1); add(SW,1,2); add(SW,0,5); add(SW,0,5); add(SW,0,5); add(SW,1,5);
    add(RT,1,0); add(RT,1,1); add(RT,1,6); add(RT,1,7);
    add(BEQ,1,0); add(BEQ,1,1); add(BEQ,1,8);
    add(JMP,1,0); add(JMP,1,1); add(JMP,1,9);
    add(ADDI,1,0); add(ADDI,1,1); add(ADDI,1,10); add(ADDI,1,11);
    add(BAD,1,0); add(BAD,1,1);
    add(BNE,1,0); add(BNE,1,1);
    if (BNE_EN) add(BNE,1,8);
    add(RT,0,0);

    // Reset state, outputs follow the S0 decode with mem_ready as applied
    rst_n = 1'b0;
    bus.opcode = LW;
    bus.mem_ready = 1'b1;
    #12;
    check("rst_state", 0, 32'(bus.state), 32'd0);
    check("rst_cnt", 0, 32'(bus.instr_cnt), 32'd0);
    check("rst_ill", 0, 32'(bus.illegal_op), 32'd0);
    check("rst_ctrl_rdy1", 0, 32'(act_ctrl), 32'(exp_ctrl(0, 1'b1, 1'b0)));
    bus.mem_ready = 1'b0;
    #1;
    check("rst_ctrl_rdy0", 0, 32'(act_ctrl), 32'(exp_ctrl(0, 1'b0, 1'b0)));
    @(posedge clk); #1;
    rst_n = 1'b1;

    exp_cnt = '0;
    lat_op  = '0;
    prev_st = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      bus.opcode    = vecs[i].op;
      bus.mem_ready = vecs[i].rdy;
      if (vecs[i].st == 1) lat_op = vecs[i].op;
      e.idx  = i;
      e.st   = vecs[i].st;
      e.ctrl = exp_ctrl(vecs[i].st, vecs[i].rdy, BNE_EN && vecs[i].st == 8 && lat_op == BNE);
      e.ill  = (prev_st == 1) && (vecs[i].st == 0);
      e.cnt  = exp_cnt;
      sb.push_back(e);
      if (vecs[i].st inside {4, 7, 8, 9, 11} || (vecs[i].st == 5 && vecs[i].rdy))
        exp_cnt = exp_cnt + 4'd1;
      prev_st = vecs[i].st;
      @(posedge clk); #1;
    end
    check("sb_drained", 0, 32'(sb.size()), 32'd0);

    // Asynchronous reset while waiting in S3
    bus.opcode = LW; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_state", 3, 32'(bus.state), 32'd3);
    check("pre_rst_cnt", 3, 32'(bus.instr_cnt), 32'(exp_cnt));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_state", 3, 32'(bus.state), 32'd0);
    check("mid_rst_cnt", 3, 32'(bus.instr_cnt), 32'd0);
    check("mid_rst_ctrl", 3, 32'(act_ctrl), 32'(exp_ctrl(0, 1'b0, 1'b0)));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 16 jumps through a 4-bit counter: wraps back to 0
    bus.opcode = JMP; bus.mem_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("j_state", k, 32'(bus.state), 32'd9);
      check("j_pc", k, 32'({bus.pc_write, bus.pc_source}), 32'b110);
      @(posedge clk); #1;
      want = 4'(k + 1);
      check("j_cnt", k, 32'(bus.instr_cnt), 32'(want));
    end
    check("wrap_state", 16, 32'(bus.state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end, expected finish");
    $fatal(1);
  end

endmodule
